// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter streaming sprite ROM runs to NUM_REQ draw engines.
// Optional SPRITE_ARB_TRANSPARENT_SKIP_EN: palette index 0 pixels consume a slot but drop pix_valid.
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 4,
   parameter int LEN_W   = 6,
   localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] base_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  run_len,
   input  logic                      abort,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      busy,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [DATA_W-1:0]         pix_data,
   output logic                      pix_valid,
   output logic [ID_W-1:0]           pix_id,
   output logic                      pix_last
);

   typedef enum logic {IDLE, BURST} state_e;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]   pix_data_q, pix_data_d;
   logic                pix_valid_q, pix_valid_d;
   logic [ID_W-1:0]     pix_id_q, pix_id_d;
   logic                pix_last_q, pix_last_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;

   logic                found;
   logic [ID_W-1:0]     win;
   logic [NUM_REQ-1:0]  win_oh;
   logic [NUM_REQ-1:0]  owner_oh;
   logic [ADDR_W-1:0]   sel_base;
   logic [LEN_W-1:0]    sel_len;
   logic                pix_show;

   // Lowest requester overall covers the wrap; lowest at/after rr overrides it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win   = ID_W'(i);
            found = 1'b1;
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i] && (ID_W'(i) >= rr_q)) begin
            win = ID_W'(i);
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      owner_oh = '0;
      sel_base = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_oh[i]   = (ID_W'(i) == win);
         owner_oh[i] = (ID_W'(i) == owner_q);
         if (ID_W'(i) == win) begin
            sel_base = base_addr[i*ADDR_W +: ADDR_W];
            sel_len  = run_len[i*LEN_W +: LEN_W];
         end
      end
   end

`ifdef SPRITE_ARB_TRANSPARENT_SKIP_EN
   assign pix_show = (rom_data != '0);
`else
   assign pix_show = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      rom_addr_d  = rom_addr_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = 1'b0;
      pix_id_d    = pix_id_q;
      pix_last_d  = 1'b0;
      gnt_d       = '0;
      done_d      = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = win_oh;
               rr_d  = (win == ID_LAST) ? '0 : win + 1'b1;
               if (sel_len == '0) begin
                  done_d = win_oh;
               end else begin
                  rom_addr_d = sel_base;
                  cnt_d      = sel_len;
                  owner_d    = win;
                  state_d    = BURST;
               end
            end
         end
         BURST: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               pix_data_d  = rom_data;
               pix_valid_d = pix_show;
               pix_id_d    = owner_q;
               rom_addr_d  = rom_addr_q + ADDR_ONE;
               cnt_d       = cnt_q - LEN_ONE;
               if (cnt_q == LEN_ONE) begin
                  pix_last_d = 1'b1;
                  done_d     = owner_oh;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         rom_addr_q  <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         pix_id_q    <= '0;
         pix_last_q  <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         rom_addr_q  <= rom_addr_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
         pix_id_q    <= pix_id_d;
         pix_last_q  <= pix_last_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q == BURST);
   assign rom_addr  = rom_addr_q;
   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;
   assign pix_id    = pix_id_q;
   assign pix_last  = pix_last_q;
   assign gnt       = gnt_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter with a behavioural ROM.
module tb_sprite_rom_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [1:0]  req = '0;
   logic [31:0] base_addr = '0;
   logic [11:0] run_len = '0;
   logic        abort = 1'b0;
   logic [1:0]  gnt, done;
   logic        busy;
   logic [15:0] rom_addr;
   logic [3:0]  rom_data, pix_data;
   logic        pix_valid;
   logic [0:0]  pix_id;
   logic        pix_last;

`ifdef SPRITE_ARB_TRANSPARENT_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic       v;
      logic [3:0] d;
      logic       id;
      logic       last;
   } pix_t;

   pix_t       pq[$];
   logic [1:0] gq[$];
   logic [1:0] dq[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;

   sprite_rom_arbiter dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .base_addr(base_addr), .run_len(run_len),
      .abort(abort), .gnt(gnt), .done(done), .busy(busy), .rom_addr(rom_addr),
      .rom_data(rom_data), .pix_data(pix_data), .pix_valid(pix_valid), .pix_id(pix_id),
      .pix_last(pix_last)
   );

   function automatic logic [3:0] rom_f(input logic [15:0] a);
      if (a == 16'h2000 || a == 16'h2002) return 4'h0;
      if (a == 16'h2001) return 4'h5;
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ 4'h9;
   endfunction

   assign rom_data = rom_f(rom_addr);

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Reset_n) begin
         if (pix_valid || pix_last) begin
            if (pq.size() == 0) chk("pix_unexpected", {25'd0, pix_valid, pix_data, pix_id, pix_last}, 32'd0);
            else chk("pix", {25'd0, pix_valid, pix_data, pix_id, pix_last}, {25'd0, pq.pop_front()});
         end
         if (gnt != 2'b00) begin
            if (gq.size() == 0) chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
            else chk("gnt", {30'd0, gnt}, {30'd0, gq.pop_front()});
         end
         if (done != 2'b00) begin
            if (dq.size() == 0) chk("done_unexpected", {30'd0, done}, 32'd0);
            else chk("done", {30'd0, done}, {30'd0, dq.pop_front()});
         end
      end
   end

   task automatic push_exp(input int id, input logic [15:0] b, input int len, input int npix);
      logic [1:0]  oh;
      logic [15:0] a;
      logic [3:0]  d;
      pix_t        e;
      oh = (id == 0) ? 2'b01 : 2'b10;
      gq.push_back(oh);
      for (int k = 0; k < npix; k++) begin
         a = b + 16'(k);
         d = rom_f(a);
         e.v    = SKIP ? (d != 4'h0) : 1'b1;
         e.d    = d;
         e.id   = id[0];
         e.last = (k == len - 1);
         if (e.v || e.last) pq.push_back(e);
      end
      if (npix == len) dq.push_back(oh);
   endtask

   task automatic issue(input int id, input logic [15:0] b, input int len, input int npix);
      int  t0;
      bit  seen;
      push_exp(id, b, len, npix);
      @(posedge Clk);
      #1;
      base_addr[id*16 +: 16] = b;
      run_len[id*6 +: 6] = 6'(len);
      req[id] = 1'b1;
      t0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         if (gnt != 2'b00) seen = 1'b1;
      end
      chk("gnt_seen", {31'd0, seen}, 32'd1);
      chk("gnt_latency", 32'(cyc - t0), 32'd1);
      req[id] = 1'b0;
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         if (!busy) idle = 1'b1;
         else @(negedge Clk);
      end
      chk("drain_idle", {31'd0, idle}, 32'd1);
      @(posedge Clk);
   endtask

   task automatic do_reset();
      #3 Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1'b1;
   endtask

   initial begin
      int gc[4];
      int ng;
      #2;
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_done", {30'd0, done}, 32'd0);
      chk("rst_busy_valid_last", {29'd0, busy, pix_valid, pix_last}, 32'd0);
      chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
      chk("rst_pix", {27'd0, pix_data, pix_id}, 32'd0);
      #20 Reset_n = 1'b1;

      // 1: single run, pixel timing
      issue(0, 16'h0100, 4, 4);
      chk("t1_addr_c1", {16'd0, rom_addr}, 32'h0100);
      chk("t1_busy_c1", {31'd0, busy}, 32'd1);
      @(negedge Clk);
      chk("t1_valid_c2", {31'd0, pix_valid}, 32'd1);
      chk("t1_addr_c2", {16'd0, rom_addr}, 32'h0101);
      repeat (3) @(negedge Clk);
      chk("t1_last_c5", {31'd0, pix_last}, 32'd1);
      chk("t1_done_c5", {30'd0, done}, 32'd1);
      @(negedge Clk);
      chk("t1_idle_c6", {30'd0, pix_valid, busy}, 32'd0);

      // 2: both held, round-robin alternation with one bubble
      do_reset();
      push_exp(0, 16'h0200, 2, 2);
      push_exp(1, 16'h0400, 2, 2);
      push_exp(0, 16'h0200, 2, 2);
      push_exp(1, 16'h0400, 2, 2);
      @(posedge Clk);
      #1;
      base_addr = {16'h0400, 16'h0200};
      run_len = {6'd2, 6'd2};
      req = 2'b11;
      ng = 0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         @(negedge Clk);
         if (gnt != 2'b00) begin
            gc[ng] = cyc;
            ng++;
         end
      end
      req = 2'b00;
      chk("t2_ngnt", 32'(ng), 32'd4);
      for (int k = 0; k < 3; k++) chk("t2_gnt_spacing", 32'(gc[k+1] - gc[k]), 32'd3);
      drain();

      // 3: address wrap
      issue(0, 16'hFFFE, 4, 4);
      chk("t3_addr_start", {16'd0, rom_addr}, 32'hFFFE);
      drain();
      chk("t3_addr_end", {16'd0, rom_addr}, 32'h0002);

      // 4: zero-length run, then abort on 3rd pixel
      issue(1, 16'h0300, 0, 0);
      @(negedge Clk);
      chk("t4_len0_busy", {31'd0, busy}, 32'd0);
      issue(0, 16'h0300, 8, 3);
      repeat (3) @(posedge Clk);
      #1 abort = 1'b1;
      @(posedge Clk);
      #1 abort = 1'b0;
      @(negedge Clk);
      chk("t4_abort_busy", {31'd0, busy}, 32'd0);
      chk("t4_abort_quiet", {28'd0, pix_valid, pix_last, done}, 32'd0);
      issue(1, 16'h0500, 2, 2);
      drain();

      // 5: async reset mid-burst
      issue(0, 16'h0600, 8, 2);
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("t5_rst_busy_valid", {30'd0, busy, pix_valid}, 32'd0);
      chk("t5_rst_addr", {16'd0, rom_addr}, 32'd0);
      chk("t5_rst_pix", {27'd0, pix_data, pix_id}, 32'd0);
      chk("t5_rst_gnt_done_last", {27'd0, gnt, done, pix_last}, 32'd0);
      dq.delete();
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1'b1;
      chk("t5_sb_flushed", 32'(pq.size() + gq.size()), 32'd0);
      issue(1, 16'h0700, 3, 3);
      drain();

      // 6: transparent pixels 0,5,0
      issue(0, 16'h2000, 3, 3);
      drain();

      repeat (3) @(posedge Clk);
      chk("end_pix_queue", 32'(pq.size()), 32'd0);
      chk("end_gnt_queue", 32'(gq.size()), 32'd0);
      chk("end_done_queue", 32'(dq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
